maxpool_2x2_16channel: RTL

MAXPOOL_2X2_16CHANNEL -- requirements
Module: maxpool_2x2_16channel

---
 rtl/maxpool_2x2_16channel_pkg.sv | 17 +
 rtl/maxpool_2x2_16channel_fp32_max.sv | 25 ++
 rtl/maxpool_2x2_16channel.sv | 114 +++++++++++
 3 files changed

// File: rtl/maxpool_2x2_16channel_pkg.sv
// Shared constants for the 2x2 max-pool block: parameter defaults, fp32 field
// positions and the row-phase type.
package maxpool_2x2_16channel_pkg;

    localparam int DATA_WIDHT_DEFAULT = 32;
    localparam int CHANNEL_DEFAULT    = 16;

    localparam int FP32_W   = 32;
    localparam int SIGN_BIT = 31;
    localparam int MAG_MSB  = 30;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } phase_e;

endpackage

// File: rtl/maxpool_2x2_16channel_fp32_max.sv
// Combinational ordering of two raw fp32 words; ties resolve to the earlier
// operand 'a'. NaN/Inf are ordered purely by their bit patterns.
module fp32_max
    import maxpool_2x2_16channel_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);

    always_comb begin
        y = a;
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            // +0 beats -0 here because the sign alone decides.
            y = a[SIGN_BIT] ? b : a;
        end else if (a[MAG_MSB:0] != b[MAG_MSB:0]) begin
            if (a[SIGN_BIT]) begin
                y = (a[MAG_MSB:0] < b[MAG_MSB:0]) ? a : b;
            end else begin
                y = (a[MAG_MSB:0] > b[MAG_MSB:0]) ? a : b;
            end
        end
    end

endmodule

// File: rtl/maxpool_2x2_16channel.sv
// Streaming 2x2/stride-2 max pool over raster-order multi-channel fp32 pixels,
// using a horizontal hold register and a half-width line buffer.
module maxpool_2x2_16channel
    import maxpool_2x2_16channel_pkg::*;
#(
    parameter int DATA_WIDHT = DATA_WIDHT_DEFAULT,
    parameter int CHANNEL    = CHANNEL_DEFAULT,
    parameter int IMG_WIDTH  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
    input  logic                          Valid_In,
    output logic [DATA_WIDHT*CHANNEL-1:0] Data_Out,
    output logic                          Valid_Out
);

    localparam int PIX_W    = DATA_WIDHT * CHANNEL;
    localparam int COL_W    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int LB_DEPTH = (IMG_WIDTH / 2 > 0) ? IMG_WIDTH / 2 : 1;
    localparam int LB_IDX_W = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    phase_e           phase_q, phase_d;
    logic             valid_out_q, valid_out_d;
    logic [PIX_W-1:0] data_out_q, data_out_d;
    logic [PIX_W-1:0] hold_q, hold_d;

    logic [PIX_W-1:0]    linebuf_q [LB_DEPTH];
    logic [LB_IDX_W-1:0] lb_idx;
    logic                lb_we;
    logic [PIX_W-1:0]    lb_rdata;
    logic [PIX_W-1:0]    hmax;
    logic [PIX_W-1:0]    vmax;

    for (genvar k = 0; k < CHANNEL; k++) begin : g_ch
        fp32_max u_hmax (
            .a(hold_q [k*DATA_WIDHT +: DATA_WIDHT]),
            .b(Data_In[k*DATA_WIDHT +: DATA_WIDHT]),
            .y(hmax   [k*DATA_WIDHT +: DATA_WIDHT])
        );
        fp32_max u_vmax (
            .a(lb_rdata[k*DATA_WIDHT +: DATA_WIDHT]),
            .b(hmax    [k*DATA_WIDHT +: DATA_WIDHT]),
            .y(vmax    [k*DATA_WIDHT +: DATA_WIDHT])
        );
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        phase_d     = phase_q;
        hold_d      = hold_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        lb_idx      = LB_IDX_W'(col_q >> 1);
        lb_rdata    = linebuf_q[lb_idx];
        lb_we       = Valid_In && (phase_q == EVEN_ROW) && col_q[0];

        if (Valid_In) begin
            if (!col_q[0]) begin
                hold_d = Data_In;
            end else if (phase_q == ODD_ROW) begin
                valid_out_d = 1'b1;
                data_out_d  = vmax;
            end

            // An odd trailing column or row is simply never paired, so it
            // falls out of the counters without producing output.
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
                phase_d = row_d[0] ? ODD_ROW : EVEN_ROW;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            phase_q     <= EVEN_ROW;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            phase_q     <= phase_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    // Hold register and line buffer are always written before being read.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (lb_we) begin
            linebuf_q[lb_idx] <= hmax;
        end
    end

    assign Data_Out  = data_out_q;
    assign Valid_Out = valid_out_q;

endmodule
